num_entry_ctrl: RTL and testbench

Sequencer for the four-digit BCD entry unit (`num_set`) used by the CPU's IN instruction. It takes the raw board push-buttons and debounces each one. It gives the entry unit one-cycle edit pulses, but only while the CPU has an input request open. When the operator presses OK, it returns the entered value to the CPU through a req/ack handshake. It sits between the board button pins, the entry unit and the CPU I/O port.

---
 rtl/num_entry_ctrl.sv | 145 ++++++++++++++
 tb/tb_num_entry_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/num_entry_ctrl.sv
// Button sequencer for the BCD entry unit behind the CPU IN instruction.
// Debounces the board buttons and hands the entered value back by req/ack.
module num_entry_ctrl #(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_ok,
  input  logic        in_req,
  output logic        in_ack,
  output logic [15:0] in_data,
  input  logic [15:0] num_data,
  output logic        up_pulse,
  output logic        down_pulse,
  output logic        h_pulse,
  output logic        l_pulse,
  output logic        clr_num,
  output logic        busy
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] CLAST = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    ACK
  } state_t;

  logic [4:0] raw;
  logic [4:0] s1;
  logic [4:0] s2;
  logic [4:0] deb;
  logic [4:0] deb_d;
  logic [4:0] p;

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 ok
  assign raw = {btn_ok, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      deb_d <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_deb
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        deb[i] <= 1'b0;
      end else if (s2[i] == deb[i]) begin
        cnt <= '0;
      end else if (cnt == CLAST) begin
        cnt    <= '0;
        deb[i] <= s2[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign p = deb & ~deb_d;

  state_t      state;
  state_t      state_n;
  logic [15:0] data_n;
  logic        up_n;
  logic        down_n;
  logic        h_n;
  logic        l_n;
  logic        clr_n;

  always_comb begin
    state_n = state;
    data_n  = in_data;
    up_n    = 1'b0;
    down_n  = 1'b0;
    h_n     = 1'b0;
    l_n     = 1'b0;
    clr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_req) begin
          state_n = ENTRY;
          clr_n   = 1'b1;
        end
      end
      ENTRY: begin
        if (!in_req) begin
          state_n = IDLE;
        end else if (p[4]) begin
          // OK wins over any edit edge in the same cycle
          state_n = ACK;
          data_n  = num_data;
        end else begin
          up_n   = p[0] & ~p[1];
          down_n = p[1] & ~p[0];
          h_n    = p[2] & ~p[3];
          l_n    = p[3] & ~p[2];
        end
      end
      ACK: begin
        if (!in_req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_data    <= '0;
      in_ack     <= 1'b0;
      busy       <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      h_pulse    <= 1'b0;
      l_pulse    <= 1'b0;
      clr_num    <= 1'b0;
    end else begin
      state      <= state_n;
      in_data    <= data_n;
      in_ack     <= (state_n == ACK);
      busy       <= (state_n != IDLE);
      up_pulse   <= up_n;
      down_pulse <= down_n;
      h_pulse    <= h_n;
      l_pulse    <= l_n;
      clr_num    <= clr_n;
    end
  end

endmodule

// File: tb/tb_num_entry_ctrl.sv
// Self-checking bench for num_entry_ctrl with a cycle-level
// window-based reference model and directed scenarios.
module tb_num_entry_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  bv = '0;
  logic        req = 1'b0;
  logic [15:0] nd = '0;
  logic        in_ack;
  logic [15:0] in_data;
  logic        up_pulse;
  logic        down_pulse;
  logic        h_pulse;
  logic        l_pulse;
  logic        clr_num;
  logic        busy;

  int nchk = 0;
  int nfail = 0;

  num_entry_ctrl #(.DEB_CNT(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (bv[0]),
    .btn_down   (bv[1]),
    .btn_left   (bv[2]),
    .btn_right  (bv[3]),
    .btn_ok     (bv[4]),
    .in_req     (req),
    .in_ack     (in_ack),
    .in_data    (in_data),
    .num_data   (nd),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .h_pulse    (h_pulse),
    .l_pulse    (l_pulse),
    .clr_num    (clr_num),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // reference model: mode 0 idle, 1 entry, 2 ack
  int          mmode;
  logic [4:0]  mdeb;
  logic [4:0]  mdeb_old;
  logic [4:0]  hist[$];
  logic [6:0]  e_out;
  logic [15:0] e_data;

  int n_up, n_down, n_h, n_l, n_clr, n_uph;

  task automatic model_reset();
    mmode = 0;
    mdeb = '0;
    mdeb_old = '0;
    hist.delete();
    e_out = '0;
    e_data = '0;
  endtask

  task automatic model_edge();
    logic [4:0] pe;
    logic [3:0] ed;
    bit         all_diff;
    int         idx;
    logic [4:0] s;
    pe = mdeb & ~mdeb_old;
    ed = '0;
    e_out[2] = 1'b0;
    case (mmode)
      0: if (req) begin
        e_out[2] = 1'b1;
        mmode = 1;
      end
      1: if (!req) mmode = 0;
         else if (pe[4]) begin
           e_data = nd;
           mmode = 2;
         end else begin
           ed[3] = pe[0] && !pe[1];
           ed[2] = pe[1] && !pe[0];
           ed[1] = pe[2] && !pe[3];
           ed[0] = pe[3] && !pe[2];
         end
      default: if (!req) mmode = 0;
    endcase
    e_out[6:3] = ed;
    e_out[1] = (mmode == 2);
    e_out[0] = (mmode != 0);
    // a level flips once the last D synchronized samples all disagree
    hist.push_back(bv);
    if (hist.size() > 16) void'(hist.pop_front());
    mdeb_old = mdeb;
    for (int b = 0; b < 5; b++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        idx = hist.size() - 3 - j;
        s = (idx >= 0) ? hist[idx] : 5'b0;
        if (s[b] == mdeb_old[b]) all_diff = 1'b0;
      end
      if (all_diff) mdeb[b] = ~mdeb_old[b];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    n_up   += int'(up_pulse);
    n_down += int'(down_pulse);
    n_h    += int'(h_pulse);
    n_l    += int'(l_pulse);
    n_clr  += int'(clr_num);
    if (up_pulse && h_pulse) n_uph++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_counts();
    n_up = 0; n_down = 0; n_h = 0; n_l = 0; n_clr = 0; n_uph = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bv = '0;
    req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if ({in_ack, in_data, up_pulse, down_pulse, h_pulse, l_pulse,
         clr_num, busy} !== 23'd0) begin
      nfail++;
      $display("FAIL reset_vals: got ack=%b data=%h pulses=%b%b%b%b clr=%b busy=%b want all 0",
               in_ack, in_data, up_pulse, down_pulse, h_pulse, l_pulse,
               clr_num, busy);
    end
    steps(3);
    clr_counts();
    req = 1'b1;
    step();
    nchk++;
    if (clr_num !== 1'b1 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL clr_enter: got clr=%b busy=%b want 1 1", clr_num, busy);
    end
    steps(5);
    nchk++;
    if (n_clr != 1 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL clr_once: got clr count=%0d busy=%b want 1 1", n_clr, busy);
    end
    nchk++;
    if (n_up + n_down + n_h + n_l != 0) begin
      nfail++;
      $display("FAIL no_edit_on_entry: got %0d pulses want 0",
               n_up + n_down + n_h + n_l);
    end
  endtask

  task automatic test_up();
    int pos;
    clr_counts();
    pos = -1;
    bv[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (up_pulse && pos < 0) pos = i;
    end
    nchk++;
    if (n_up != 1 || pos != 7) begin
      nfail++;
      $display("FAIL up_press: got count=%0d at cycle %0d want 1 at 7", n_up, pos);
    end
    bv[0] = 1'b0;
    steps(10);
    clr_counts();
    for (int r = 0; r < 3; r++) begin
      bv[0] = 1'b1; steps(3);
      bv[0] = 1'b0; steps(1);
    end
    steps(10);
    nchk++;
    if (n_up != 0) begin
      nfail++;
      $display("FAIL up_bounce: got %0d pulses want 0", n_up);
    end
  endtask

  task automatic test_ok();
    clr_counts();
    nd = 16'h1234;
    bv[4] = 1'b1;
    bv[1] = 1'b1;
    steps(12);
    nchk++;
    if (n_down != 0 || in_data !== 16'h1234 || in_ack !== 1'b1) begin
      nfail++;
      $display("FAIL ok_capture: got down=%0d data=%h ack=%b want 0 1234 1",
               n_down, in_data, in_ack);
    end
    bv = '0;
    nd = 16'hffff;
    steps(8);
    req = 1'b0;
    step();
    nchk++;
    if (in_ack !== 1'b0 || busy !== 1'b0 || in_data !== 16'h1234) begin
      nfail++;
      $display("FAIL ack_drop: got ack=%b busy=%b data=%h want 0 0 1234",
               in_ack, busy, in_data);
    end
  endtask

  task automatic test_simul();
    req = 1'b1;
    steps(3);
    clr_counts();
    bv[0] = 1'b1; bv[1] = 1'b1;
    steps(12);
    bv = '0;
    steps(10);
    nchk++;
    if (n_up != 0 || n_down != 0) begin
      nfail++;
      $display("FAIL up_down_same: got up=%0d down=%0d want 0 0", n_up, n_down);
    end
    clr_counts();
    bv[0] = 1'b1; bv[2] = 1'b1;
    steps(12);
    bv = '0;
    steps(10);
    nchk++;
    if (n_uph != 1 || n_up != 1 || n_h != 1) begin
      nfail++;
      $display("FAIL up_left_same: got joint=%0d up=%0d h=%0d want 1 1 1",
               n_uph, n_up, n_h);
    end
  endtask

  task automatic test_idle_ack();
    req = 1'b0;
    steps(3);
    clr_counts();
    bv[0] = 1'b1; bv[3] = 1'b1;
    steps(12);
    bv = '0;
    steps(10);
    nchk++;
    if (n_up + n_l != 0) begin
      nfail++;
      $display("FAIL idle_press: got %0d pulses want 0", n_up + n_l);
    end
    req = 1'b1;
    nd = 16'h5555;
    steps(3);
    bv[4] = 1'b1;
    steps(12);
    bv = '0;
    steps(10);
    clr_counts();
    bv[1] = 1'b1; bv[2] = 1'b1;
    steps(12);
    bv = '0;
    steps(10);
    nchk++;
    if (n_down + n_h != 0 || in_ack !== 1'b1 || in_data !== 16'h5555) begin
      nfail++;
      $display("FAIL ack_press: got pulses=%0d ack=%b data=%h want 0 1 5555",
               n_down + n_h, in_ack, in_data);
    end
    req = 1'b0;
    steps(2);
    req = 1'b1;
    nd = 16'h7777;
    steps(4);
    req = 1'b0;
    steps(3);
    nchk++;
    if (in_ack !== 1'b0 || busy !== 1'b0 || in_data !== 16'h5555) begin
      nfail++;
      $display("FAIL abort: got ack=%b busy=%b data=%h want 0 0 5555",
               in_ack, busy, in_data);
    end
  endtask

  task automatic test_reset_ack();
    req = 1'b1;
    nd = 16'h9876;
    steps(3);
    bv[4] = 1'b1;
    steps(12);
    nchk++;
    if (in_ack !== 1'b1 || in_data !== 16'h9876) begin
      nfail++;
      $display("FAIL pre_reset_ack: got ack=%b data=%h want 1 9876", in_ack, in_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (in_ack !== 1'b0 || in_data !== 16'h0000 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: got ack=%b data=%h busy=%b want 0 0000 0",
               in_ack, in_data, busy);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [6:0] got;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 9) == 0) bv[b] = ~bv[b];
      if ($urandom_range(0, 59) == 0) req = ~req;
      nd = 16'($urandom);
      step();
      got = {up_pulse, down_pulse, h_pulse, l_pulse, clr_num, in_ack, busy};
      nchk++;
      if (got !== e_out || in_data !== e_data) begin
        nfail++;
        $display("FAIL random_cycle %0d: got out=%b data=%h want out=%b data=%h",
                 c, got, in_data, e_out, e_data);
      end
    end
  endtask

  initial begin
    model_reset();
    clr_counts();
    test_reset();
    test_up();
    test_ok();
    test_simul();
    test_idle_ack();
    test_reset_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
